// File: rtl/uart_frame_pkg.sv
// Shared framing constants, FSM state encoding and small byte helpers used by
// the UART transmit arbiter and its bench.
package uart_frame_pkg;

   localparam int         MAX_SRC         = 8;
   localparam logic [7:0] FRAME_SYNC      = 8'hAA;
   localparam logic [7:0] TYPE_MOUSE_HOST = 8'h06;
   localparam logic [7:0] TYPE_DEBUG      = 8'h07;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_AA = 3'd1,
      LEN_H  = 3'd2,
      LEN_L  = 3'd3,
      TYPE   = 3'd4,
      DATA   = 3'd5,
      CSUM   = 3'd6,
      FIN    = 3'd7
   } state_t;

   // Length field counts the type byte plus the payload, never the trailer.
   function automatic logic [15:0] frame_len(input logic [7:0] plen);
      return {8'h00, plen} + 16'd1;
   endfunction

   function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Source-side request bundle plus transmitter handshake of the UART TX arbiter.
// master = arbiter, slave = sources/transmitter side.
interface uart_tx_arbiter_if #(
   parameter int N_SRC = 3
);
   logic [N_SRC-1:0]   req_valid;
   logic [8*N_SRC-1:0] req_type;
   logic [8*N_SRC-1:0] req_len;
   logic [8*N_SRC-1:0] req_data;
   logic [N_SRC-1:0]   req_rd;
   logic [N_SRC-1:0]   req_done;
   logic [7:0]         tx_data;
   logic               tx_start;
   logic               tx_busy;
   logic               busy;
   logic [2:0]         grant;

   modport master (
      input  req_valid, req_type, req_len, req_data, tx_busy,
      output req_rd, req_done, tx_data, tx_start, busy, grant
   );

   modport slave (
      output req_valid, req_type, req_len, req_data, tx_busy,
      input  req_rd, req_done, tx_data, tx_start, busy, grant
   );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping around at N_SRC.
module uart_tx_arbiter_rr_pick #(
   parameter int N_SRC = 3
) (
   input  logic [N_SRC-1:0] i_req,
   input  logic [2:0]       i_ptr,
   output logic [2:0]       o_idx,
   output logic             o_hit
);

   logic [7:0] w_req_pad;
   logic [3:0] w_cand;

   // Walk the candidates in priority order starting from the pointer.
   always_comb begin
      w_req_pad = 8'(i_req);
      w_cand    = 4'd0;
      o_idx     = 3'd0;
      o_hit     = 1'b0;
      for (int k = 0; k < N_SRC; k++) begin
         w_cand = {1'b0, i_ptr} + 4'(k);
         w_cand = (w_cand >= 4'(N_SRC)) ? (w_cand - 4'(N_SRC)) : w_cand;
         if (w_req_pad[w_cand[2:0]] && !o_hit) begin
            o_hit = 1'b1;
            o_idx = w_cand[2:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter serialising framed messages (AA, len_hi, len_lo, type,
// payload) onto one UART transmitter. Optional XOR trailer: UART_TX_ARB_CHECKSUM_EN.
module uart_tx_arbiter
   import uart_frame_pkg::*;
#(
   parameter int N_SRC    = 3,
   parameter int CLK_FREQ = 20_000_000
) (
   input  logic              clk,
   input  logic              reset,
   uart_tx_arbiter_if.master bus
);

   if (N_SRC < 1 || N_SRC > MAX_SRC || CLK_FREQ < 1) begin : g_bad_param
      $error("uart_tx_arbiter: N_SRC must be 1..8 and CLK_FREQ positive");
   end

`ifdef UART_TX_ARB_CHECKSUM_EN
   localparam state_t TAIL = CSUM;
`else
   localparam state_t TAIL = FIN;
`endif

   state_t             r_state, w_state;
   logic [2:0]         r_grant, w_grant;
   logic [2:0]         r_rr_ptr, w_rr_ptr;
   logic [7:0]         r_type, w_type;
   logic [7:0]         r_plen, w_plen;
   logic [15:0]        r_flen, w_flen;
   logic [7:0]         r_cnt, w_cnt;
   logic [7:0]         r_tx_data, w_tx_data;
   logic               r_tx_start, w_tx_start;
   logic               r_busy, w_busy;
   logic [N_SRC-1:0]   r_req_rd, w_req_rd;
   logic [N_SRC-1:0]   r_req_done, w_req_done;
`ifdef UART_TX_ARB_CHECKSUM_EN
   logic [7:0]         r_csum, w_csum;
`endif

   logic [2:0]         w_pick;
   logic               w_hit;
   logic               w_issue;
   logic [7:0]         w_sel_type;
   logic [7:0]         w_sel_len;
   logic [7:0]         w_cur_data;
   logic [N_SRC-1:0]   w_grant_oh;

   uart_tx_arbiter_rr_pick #(.N_SRC(N_SRC)) u_rr_pick (
      .i_req (bus.req_valid),
      .i_ptr (r_rr_ptr),
      .o_idx (w_pick),
      .o_hit (w_hit)
   );

   // Per-source field muxes for the candidate and the current owner.
   always_comb begin
      w_sel_type = 8'h00;
      w_sel_len  = 8'h00;
      w_cur_data = 8'h00;
      w_grant_oh = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_sel_type    = (w_pick == 3'(i))  ? bus.req_type[8*i +: 8] : w_sel_type;
         w_sel_len     = (w_pick == 3'(i))  ? bus.req_len[8*i +: 8]  : w_sel_len;
         w_cur_data    = (r_grant == 3'(i)) ? bus.req_data[8*i +: 8] : w_cur_data;
         w_grant_oh[i] = (r_grant == 3'(i));
      end
   end

   // Next-state and next-output logic; a byte leaves only when the transmitter is idle
   // and no strobe is in flight, which also absorbs its one-cycle busy latency.
   always_comb begin
      w_issue    = !bus.tx_busy && !r_tx_start;
      w_state    = r_state;
      w_grant    = r_grant;
      w_rr_ptr   = r_rr_ptr;
      w_type     = r_type;
      w_plen     = r_plen;
      w_flen     = r_flen;
      w_cnt      = r_cnt;
      w_tx_data  = r_tx_data;
      w_tx_start = 1'b0;
      w_req_rd   = '0;
      w_req_done = '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
      w_csum     = r_csum;
`endif
      case (r_state)
         IDLE: begin
            if (w_hit) begin
               w_grant = w_pick;
               w_type  = w_sel_type;
               w_plen  = w_sel_len;
               w_flen  = frame_len(w_sel_len);
               w_state = HDR_AA;
            end else begin
               w_state = IDLE;
            end
         end
         HDR_AA: begin
            if (w_issue) begin
               w_tx_data  = FRAME_SYNC;
               w_tx_start = 1'b1;
               w_state    = LEN_H;
            end else begin
               w_state = HDR_AA;
            end
         end
         LEN_H: begin
            if (w_issue) begin
               w_tx_data  = r_flen[15:8];
               w_tx_start = 1'b1;
               w_state    = LEN_L;
            end else begin
               w_state = LEN_H;
            end
         end
         LEN_L: begin
            if (w_issue) begin
               w_tx_data  = r_flen[7:0];
               w_tx_start = 1'b1;
               w_state    = TYPE;
            end else begin
               w_state = LEN_L;
            end
         end
         TYPE: begin
            if (w_issue) begin
               w_tx_data  = r_type;
               w_tx_start = 1'b1;
`ifdef UART_TX_ARB_CHECKSUM_EN
               w_csum     = r_type;
`endif
               if (r_plen == 8'd0) begin
                  w_state = TAIL;
               end else begin
                  w_cnt   = 8'd0;
                  w_state = DATA;
               end
            end else begin
               w_state = TYPE;
            end
         end
         DATA: begin
            if (w_issue) begin
               w_tx_data  = w_cur_data;
               w_tx_start = 1'b1;
               w_req_rd   = w_grant_oh;
`ifdef UART_TX_ARB_CHECKSUM_EN
               w_csum     = csum_step(r_csum, w_cur_data);
`endif
               if ((r_cnt + 8'd1) == r_plen) begin
                  w_state = TAIL;
               end else begin
                  w_cnt   = r_cnt + 8'd1;
                  w_state = DATA;
               end
            end else begin
               w_state = DATA;
            end
         end
`ifdef UART_TX_ARB_CHECKSUM_EN
         CSUM: begin
            if (w_issue) begin
               w_tx_data  = r_csum;
               w_tx_start = 1'b1;
               w_state    = FIN;
            end else begin
               w_state = CSUM;
            end
         end
`endif
         FIN: begin
            if (w_issue) begin
               w_req_done = w_grant_oh;
               w_rr_ptr   = (r_grant == 3'(N_SRC - 1)) ? 3'd0 : (r_grant + 3'd1);
               w_state    = IDLE;
            end else begin
               w_state = FIN;
            end
         end
         default: begin
            w_state = IDLE;
         end
      endcase
      w_busy = (w_state != IDLE);
   end

   // State and output registers; reset aborts any frame without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_grant    <= 3'd0;
         r_rr_ptr   <= 3'd0;
         r_type     <= 8'h00;
         r_plen     <= 8'h00;
         r_flen     <= 16'h0000;
         r_cnt      <= 8'h00;
         r_tx_data  <= 8'h00;
         r_tx_start <= 1'b0;
         r_busy     <= 1'b0;
         r_req_rd   <= '0;
         r_req_done <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
         r_csum     <= 8'h00;
`endif
      end else begin
         r_state    <= w_state;
         r_grant    <= w_grant;
         r_rr_ptr   <= w_rr_ptr;
         r_type     <= w_type;
         r_plen     <= w_plen;
         r_flen     <= w_flen;
         r_cnt      <= w_cnt;
         r_tx_data  <= w_tx_data;
         r_tx_start <= w_tx_start;
         r_busy     <= w_busy;
         r_req_rd   <= w_req_rd;
         r_req_done <= w_req_done;
`ifdef UART_TX_ARB_CHECKSUM_EN
         r_csum     <= w_csum;
`endif
      end
   end

   assign bus.req_rd   = r_req_rd;
   assign bus.req_done = r_req_done;
   assign bus.tx_data  = r_tx_data;
   assign bus.tx_start = r_tx_start;
   assign bus.busy     = r_busy;
   assign bus.grant    = r_grant;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a 10-cycle-busy transmitter model
// and FWFT source buffers.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   import uart_frame_pkg::*;

   localparam int N     = 3;
   localparam int LIMIT = 20000;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.N_SRC(N)) bus ();

   uart_tx_arbiter #(.N_SRC(N), .CLK_FREQ(20_000_000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0] mem [N][256];
   logic [7:0] rp [N];
   logic [7:0] wp [N];
   logic [7:0] src_type [N];
   logic [7:0] src_len [N];
   logic [N-1:0] valid;
   logic stall;
   int   busy_cnt = 0;

   int vectors = 0;
   int miscompares = 0;
   int tx_cnt = 0;
   int done_cnt = 0;
   int rd_cnt [N];
   logic [7:0] exp_q [$];
   int exp_done [$];

   for (genvar gi = 0; gi < N; gi++) begin : g_src
      assign bus.req_data[8*gi +: 8] = mem[gi][rp[gi]];
      assign bus.req_type[8*gi +: 8] = src_type[gi];
      assign bus.req_len[8*gi +: 8]  = src_len[gi];
   end
   assign bus.req_valid = valid;
   assign bus.tx_busy   = (busy_cnt != 0) || stall;

   // Transmitter model: busy for 10 cycles after each accepted start strobe.
   always @(posedge clk) begin
      if (bus.tx_start) busy_cnt <= 10;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_frame(input int src, input logic [7:0] typ, input int len,
                             input logic [7:0] seed, input logic [7:0] step);
      logic [15:0] flen;
      logic [7:0]  b;
`ifdef UART_TX_ARB_CHECKSUM_EN
      logic [7:0]  cs;
      cs = typ;
`endif
      flen = 16'(len + 1);
      src_type[src] = typ;
      src_len[src]  = 8'(len);
      exp_q.push_back(8'hAA);
      exp_q.push_back(flen[15:8]);
      exp_q.push_back(flen[7:0]);
      exp_q.push_back(typ);
      for (int k = 0; k < len; k++) begin
         b = seed + 8'(k) * step;
         mem[src][wp[src]] = b;
         wp[src] = wp[src] + 8'd1;
         exp_q.push_back(b);
`ifdef UART_TX_ARB_CHECKSUM_EN
         cs = cs ^ b;
`endif
      end
`ifdef UART_TX_ARB_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
      exp_done.push_back(src);
   endtask

   task automatic monitor();
      logic [7:0] e;
      int d;
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1) begin
            tx_cnt++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("tx_byte", 32'(bus.tx_data), 32'(e));
            end else begin
               chk("tx_unexpected", exp_q.size(), 1);
            end
         end
         if (bus.req_rd != '0) begin
            chk("rd_onehot", $countones(bus.req_rd), 1);
            chk("rd_with_start", 32'(bus.tx_start), 1);
            for (int i = 0; i < N; i++) begin
               if (bus.req_rd[i]) begin
                  rd_cnt[i]++;
                  rp[i] = rp[i] + 8'd1;
               end
            end
         end
         if (stall && (bus.tx_start || bus.req_rd != '0)) begin
            chk("stall_quiet", {bus.tx_start, 8'(bus.req_rd)}, 0);
         end
         if (bus.req_done != '0) begin
            done_cnt++;
            if (exp_done.size() > 0) begin
               d = exp_done.pop_front();
               chk("req_done", 32'(bus.req_done), 32'(1) << d);
            end else begin
               chk("done_unexpected", exp_done.size(), 1);
            end
         end
      end
   endtask

   task automatic wait_done(input int target, input string tag);
      int guard = 0;
      while (done_cnt < target && guard < LIMIT) begin
         @(negedge clk); #1; guard++;
      end
      chk(tag, done_cnt, target);
   endtask

   task automatic wait_grant(input int src, input string tag);
      int guard = 0;
      while (!(bus.busy === 1'b1 && bus.grant === 3'(src)) && guard < LIMIT) begin
         @(negedge clk); #1; guard++;
      end
      chk(tag, {bus.busy, bus.grant}, {1'b1, 3'(src)});
   endtask

   task automatic wait_rd(input int src, input int target, input string tag);
      int guard = 0;
      while (rd_cnt[src] < target && guard < LIMIT) begin
         @(negedge clk); #1; guard++;
      end
      chk(tag, rd_cnt[src], target);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tx_start"}, 32'(bus.tx_start), 0);
      chk({tag, "_tx_data"},  32'(bus.tx_data), 0);
      chk({tag, "_req_rd"},   32'(bus.req_rd), 0);
      chk({tag, "_req_done"}, 32'(bus.req_done), 0);
      chk({tag, "_busy"},     32'(bus.busy), 0);
      chk({tag, "_grant"},    32'(bus.grant), 0);
   endtask

   initial begin
      int base;
      int snap_tx;
      int snap_rd;
      valid = '0;
      stall = 1'b0;
      for (int i = 0; i < N; i++) begin
         rp[i] = 8'd0; wp[i] = 8'd0; src_type[i] = 8'h00; src_len[i] = 8'h00; rd_cnt[i] = 0;
      end
      fork
         monitor();
      join_none

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      reset = 1'b0;

      // Single source 1, one payload byte.
      load_frame(1, TYPE_MOUSE_HOST, 1, 8'h5A, 8'h00);
      valid[1] = 1'b1;
      wait_grant(1, "t1_grant");
      valid[1] = 1'b0;
      wait_done(1, "t1_done");
      chk("t1_rd", rd_cnt[1], 1);
      chk("t1_idle", 32'(bus.busy), 0);

      // Source 0, empty payload.
      load_frame(0, TYPE_DEBUG, 0, 8'h00, 8'h00);
      valid[0] = 1'b1;
      wait_grant(0, "t2_grant");
      valid[0] = 1'b0;
      wait_done(2, "t2_done");
      chk("t2_rd", rd_cnt[0], 0);

      // Maximum payload from source 2: length field 0x0100.
      load_frame(2, 8'h33, 255, 8'h01, 8'h01);
      valid[2] = 1'b1;
      wait_grant(2, "t3_grant");
      valid[2] = 1'b0;
      wait_done(3, "t3_done");
      chk("t3_rd", rd_cnt[2], 255);

      // All sources continuously valid: expect 0,1,2,0,1,2.
      for (int r = 0; r < 2; r++) begin
         for (int s = 0; s < N; s++) begin
            load_frame(s, 8'h10 + 8'(s), 2, 8'(8'hC0 + 8'(16 * r + 4 * s)), 8'h03);
         end
      end
      valid = 3'b111;
      wait_done(9, "t4_done");
      valid = '0;
      chk("t4_rd0", rd_cnt[0], 4);
      chk("t4_rd1", rd_cnt[1], 5);
      chk("t4_rd2", rd_cnt[2], 259);

      // Transmitter stalled mid-payload for 1000 cycles.
      base = rd_cnt[0];
      load_frame(0, 8'h21, 20, 8'h40, 8'h05);
      valid[0] = 1'b1;
      wait_grant(0, "t5_grant");
      valid[0] = 1'b0;
      wait_rd(0, base + 5, "t5_mid");
      stall = 1'b1;
      snap_tx = tx_cnt;
      snap_rd = rd_cnt[0];
      repeat (1000) @(negedge clk);
      #1;
      chk("t5_stall_tx", tx_cnt, snap_tx);
      chk("t5_stall_rd", rd_cnt[0], snap_rd);
      chk("t5_stall_busy", 32'(bus.busy), 1);
      stall = 1'b0;
      wait_done(10, "t5_done");
      chk("t5_rd", rd_cnt[0], base + 20);

      // Type 0x06 with payload 12 34 (trailer 0x20 when the checksum is built in).
      load_frame(1, TYPE_MOUSE_HOST, 2, 8'h12, 8'h22);
      valid[1] = 1'b1;
      wait_grant(1, "t6_grant");
      valid[1] = 1'b0;
      wait_done(11, "t6_done");

      // Reset during DATA: abort, no done pulse, pointer back to 0.
      base = rd_cnt[2];
      load_frame(2, 8'h44, 10, 8'h80, 8'h01);
      valid[2] = 1'b1;
      wait_grant(2, "t7_grant");
      valid[2] = 1'b0;
      wait_rd(2, base + 3, "t7_mid");
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk_reset_outputs("t7_abort");
      exp_q.delete();
      exp_done.delete();
      rp[2] = wp[2];
      @(negedge clk);
      reset = 1'b0;

      // Sources 1 and 2 together after reset: 1 wins from pointer 0.
      load_frame(1, 8'h51, 1, 8'h99, 8'h00);
      load_frame(2, 8'h52, 1, 8'h77, 8'h00);
      valid = 3'b110;
      wait_grant(1, "t8_grant1");
      valid[1] = 1'b0;
      wait_grant(2, "t8_grant2");
      valid[2] = 1'b0;
      wait_done(13, "t8_done");

      repeat (30) @(negedge clk);
      #1;
      chk("end_bytes_left", exp_q.size(), 0);
      chk("end_done_left", exp_done.size(), 0);
      chk("end_idle", 32'(bus.busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
